// File: rtl/lab2_pkg.sv
// lab2_pkg: shared widths and types for the lab2 datapath.
// Exports SUM_W (adder operand width, shared with multer/cqrt ports),
// SUM_N (number of shared-adder clients) and the lock FSM state type.
package lab2_pkg;
  localparam int SUM_W = 8;
  localparam int SUM_N = 2;
  typedef enum logic {LK_FREE, LK_HELD} lock_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational N-way round-robin pick starting after last.
// Ports: req (request vector), last (index served previously),
//        grant (one-hot winner), idx (winner index), valid (any request).
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);
  localparam int IW = $clog2(N);
  // Two descending passes: the wrapped range 0..last first, then last+1..N-1
  // overrides it, so the lowest index above last wins, else the lowest overall.
  always_comb begin
    idx = '0;
    for (int j = N - 1; j >= 0; j--) if (req[j] && j <= int'(last)) idx = IW'(j);
    for (int j = N - 1; j >= 0; j--) if (req[j] && j > int'(last)) idx = IW'(j);
  end
  assign valid = |req;
  assign grant = valid ? N'(1) << idx : '0;
endmodule

// File: rtl/sum_server.sv
// sum_server: time-shared adder serving N clients over req/gnt/done with bus lock.
// Ports: clk, rst (sync active-high), req/lock/cin (per client), a/b (flattened
//        operands, client i at [i*WIDTH +: WIDTH]), gnt/done (registered one-hot),
//        y (registered WIDTH+1 sum, holds when idle), busy (combinational).
module sum_server
  import lab2_pkg::*;
#(
  parameter int WIDTH = SUM_W,
  parameter int N     = SUM_N
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N-1:0]       lock,
  input  logic [N-1:0]       cin,
  input  logic [N*WIDTH-1:0] a,
  input  logic [N*WIDTH-1:0] b,
  output logic [N-1:0]       gnt,
  output logic [N-1:0]       done,
  output logic [WIDTH:0]     y,
  output logic               busy
);
  localparam int IW = $clog2(N);
  lock_e            lock_q, lock_d;
  logic [IW-1:0]    owner_q, owner_d, last_q, last_d, win, sel;
  logic [N-1:0]     gnt_q, gnt_d, win_oh;
  logic [WIDTH:0]   y_q, y_d;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic             win_ok, hold, fire, c_sel;
  // last stays frozen while locked, so it equals owner and the arbiter
  // naturally restarts at owner+1 on the releasing edge.
  rr_arbiter #(.N(N)) u_arb (
    .req  (req),
    .last (last_q),
    .grant(win_oh),
    .idx  (win),
    .valid(win_ok)
  );
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    c_sel = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (sel == IW'(j)) begin
        a_sel = a[j*WIDTH +: WIDTH];
        b_sel = b[j*WIDTH +: WIDTH];
        c_sel = cin[j];
      end
    end
  end
  always_comb begin
    hold    = lock_q == LK_HELD && req[owner_q] && lock[owner_q];
    sel     = hold ? owner_q : win;
    fire    = hold || win_ok;
    gnt_d   = hold ? N'(1) << owner_q : win_oh;
    y_d     = fire ? {1'b0, a_sel} + {1'b0, b_sel} + (WIDTH+1)'(c_sel) : y_q;
    last_d  = (!hold && win_ok) ? win : last_q;
    lock_d  = (hold || (win_ok && lock[win])) ? LK_HELD : LK_FREE;
    owner_d = (!hold && win_ok && lock[win]) ? win : owner_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q  <= LK_FREE;
      owner_q <= '0;
      last_q  <= IW'(N - 1);
      gnt_q   <= '0;
      y_q     <= '0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      y_q     <= y_d;
    end
  end
  assign gnt  = gnt_q;
  assign done = gnt_q;
  assign y    = y_q;
  assign busy = |req || lock_q == LK_HELD;
endmodule

// File: tb/tb_sum_server.sv
// tb_sum_server: directed checks of sum_server with N=2, WIDTH=8.
module tb_sum_server;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, lock, cin, gnt, done;
  logic [7:0] a0, a1, b0, b1;
  logic [8:0] y;
  logic       busy;
  int         n_chk = 0;
  int         n_fail = 0;

  sum_server #(.WIDTH(8), .N(2)) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .lock(lock),
    .cin (cin),
    .a   ({a1, a0}),
    .b   ({b1, b0}),
    .gnt (gnt),
    .done(done),
    .y   (y),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = '0; lock = '0; cin = '0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_done", 32'(done), 0);
    check("rst_y", 32'(y), 0);
    check("rst_busy", 32'(busy), 0);
    // single client 0
    a0 = 8'd5; b0 = 8'd10; cin = 2'b00; req = 2'b01;
    #1 check("busy_req", 32'(busy), 1);
    tick();
    check("s0_gnt", 32'(gnt), 32'h1);
    check("s0_done", 32'(done), 32'h1);
    check("s0_y", 32'(y), 15);
    a0 = 8'hFF; b0 = 8'hFF; cin = 2'b01;
    tick();
    check("s1_gnt", 32'(gnt), 32'h1);
    check("s1_y", 32'(y), 32'h1FF);
    req = '0;
    tick();
    check("idle_gnt", 32'(gnt), 0);
    check("idle_y_hold", 32'(y), 32'h1FF);
    // subtraction on client 1
    a1 = 8'd20; b1 = ~8'd7; cin = 2'b10; req = 2'b10;
    tick();
    check("sub_gnt", 32'(gnt), 32'h2);
    check("sub_y", 32'(y), 32'h10D);
    req = '0;
    tick();
    // contention from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a0 = 8'd1; b0 = 8'd2; a1 = 8'd4; b1 = 8'd5; cin = '0; req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rr_gnt%0d", k), 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
      check($sformatf("rr_y%0d", k), 32'(y), (k % 2 == 0) ? 32'd3 : 32'd9);
    end
    // lock: client 1 alone takes the bus locked, then client 0 also requests
    a1 = 8'd20; b1 = ~8'd7; cin = 2'b10; req = 2'b10; lock = 2'b10;
    tick();
    check("lk1_gnt", 32'(gnt), 32'h2);
    check("lk1_y", 32'(y), 32'h10D);
    req = 2'b00;
    #1 check("lk_busy", 32'(busy), 1);
    req = 2'b11; a1 = 8'd3; b1 = 8'd4; cin = 2'b00;
    tick();
    check("lk2_gnt", 32'(gnt), 32'h2);
    check("lk2_y", 32'(y), 7);
    a1 = 8'h80; b1 = 8'h80;
    tick();
    check("lk3_gnt", 32'(gnt), 32'h2);
    check("lk3_y", 32'(y), 32'h100);
    lock = 2'b00;
    tick();
    check("unlk_gnt", 32'(gnt), 32'h1);
    check("unlk_y", 32'(y), 3);
    tick();
    check("unlk_next", 32'(gnt), 32'h2);
    // reset mid-operation while a locked grant would occur
    lock = 2'b10;
    rst = 1'b1;
    tick();
    check("mid_gnt", 32'(gnt), 0);
    check("mid_done", 32'(done), 0);
    check("mid_y", 32'(y), 0);
    req = 2'b00;
    #1 check("mid_unlocked", 32'(busy), 0);
    rst = 1'b0; lock = 2'b00; a0 = 8'd9; b0 = 8'd6; req = 2'b01;
    tick();
    check("rereq_gnt", 32'(gnt), 32'h1);
    check("rereq_y", 32'(y), 15);
    req = '0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  always @(negedge clk) begin
    if (!rst && $countones(gnt) > 1) begin
      n_fail++;
      $display("FAIL onehot: gnt %b has more than one bit", gnt);
    end
  end
endmodule
